// File: rtl/hpi_pkg.sv
// Shared HPI definitions: port-select encoding, status register bit layout
// and a helper that assembles the status word.
package hpi_pkg;

    typedef enum logic [1:0] {
        HPI_DATA    = 2'd0,
        HPI_MAILBOX = 2'd1,
        HPI_ADDRESS = 2'd2,
        HPI_STATUS  = 2'd3
    } hpi_port_t;

    localparam int ST_D2H_FULL = 0;
    localparam int ST_H2D_FULL = 1;

    function automatic logic [15:0] hpi_status_word(input logic h2d_full,
                                                    input logic d2h_full);
        logic [15:0] word;
        word = '0;
        word[ST_D2H_FULL] = d2h_full;
        word[ST_H2D_FULL] = h2d_full;
        return word;
    endfunction

endpackage

// File: rtl/hpi_strobe_edge.sv
// Turns qualified HPI strobes into single-cycle write-commit and read-end
// pulses; shared with the host-side bench monitor.
module hpi_strobe_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic wr_act,
    input  logic rd_act,
    output logic wr_commit,
    output logic rd_end
);

    logic wr_hist_q, wr_hist_d;
    logic rd_hist_q, rd_hist_d;

    // Write history parks at "active" during any clear so a strobe held
    // across reset needs a fresh falling edge before it can commit again.
    always_comb begin
        wr_hist_d = wr_act;
        rd_hist_d = rd_act;
        if (clr) begin
            wr_hist_d = 1'b1;
            rd_hist_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_hist_q <= 1'b1;
            rd_hist_q <= 1'b0;
        end else begin
            wr_hist_q <= wr_hist_d;
            rd_hist_q <= rd_hist_d;
        end
    end

    assign wr_commit = wr_act & ~wr_hist_q & ~clr;
    assign rd_end    = ~rd_act & rd_hist_q & ~clr;

endmodule

// File: rtl/hpi_target.sv
// Device-side responder for the four-register HPI port: word memory behind an
// auto-incrementing pointer, bidirectional mailbox and status register.
module hpi_target
    import hpi_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH) + 1
) (
    input  logic        Clk,
    input  logic        Reset_N,
    inout  wire  [15:0] OTG_DATA,
    input  logic [1:0]  OTG_ADDR,
    input  logic        OTG_RD_N,
    input  logic        OTG_WR_N,
    input  logic        OTG_CS_N,
    input  logic        OTG_RST_N,
    output logic        OTG_INT,
    input  logic        dev_mbx_wr,
    input  logic [15:0] dev_mbx_wdata,
    output logic [15:0] dev_mbx_rdata,
    output logic        dev_mbx_valid,
    input  logic        dev_mbx_ack
);

    logic        wr_act;
    logic        rd_act;
    logic        clr;
    logic        wr_commit;
    logic        rd_end;
    logic        bus_drive;
    hpi_port_t   port_sel;

    logic [AW-1:0] addr_ptr_q, addr_ptr_d;
    logic [15:0]   h2d_data_q, h2d_data_d;
    logic [15:0]   d2h_data_q, d2h_data_d;
    logic          h2d_full_q, h2d_full_d;
    logic          d2h_full_q, d2h_full_d;
    hpi_port_t     rd_port_q, rd_port_d;

    logic [15:0]   mem [DEPTH];
    logic          mem_we;
    logic [AW-2:0] mem_waddr;
    logic [15:0]   mem_rdata;
    logic [15:0]   ptr_word;
    logic [15:0]   rd_mux;

    // A simultaneous RD/WR is treated as a write, so rd_act requires WR_N high.
    assign wr_act   = ~OTG_CS_N & ~OTG_WR_N;
    assign rd_act   = ~OTG_CS_N & ~OTG_RD_N & OTG_WR_N;
    assign clr      = ~OTG_RST_N;
    assign port_sel = hpi_port_t'(OTG_ADDR);

    hpi_strobe_edge u_strobe_edge (
        .clk       (Clk),
        .rst_n     (Reset_N),
        .clr       (clr),
        .wr_act    (wr_act),
        .rd_act    (rd_act),
        .wr_commit (wr_commit),
        .rd_end    (rd_end)
    );

    // Ordering: read-end side effects, device mailbox traffic, host write
    // commit, then host chip reset, so later events override earlier ones.
    always_comb begin
        addr_ptr_d = addr_ptr_q;
        h2d_data_d = h2d_data_q;
        d2h_data_d = d2h_data_q;
        h2d_full_d = h2d_full_q;
        d2h_full_d = d2h_full_q;
        rd_port_d  = rd_act ? port_sel : rd_port_q;
        mem_we     = 1'b0;
        mem_waddr  = addr_ptr_q[AW-1:1];

        if (rd_end) begin
            case (rd_port_q)
                HPI_DATA:    addr_ptr_d = addr_ptr_q + AW'(2);
                HPI_MAILBOX: d2h_full_d = 1'b0;
                default:     ;
            endcase
        end

        if (dev_mbx_ack) begin
            h2d_full_d = 1'b0;
        end

        if (dev_mbx_wr) begin
            d2h_data_d = dev_mbx_wdata;
            d2h_full_d = 1'b1;
        end

        if (wr_commit) begin
            case (port_sel)
                HPI_ADDRESS: addr_ptr_d = {OTG_DATA[AW-1:1], 1'b0};
                HPI_DATA: begin
                    mem_we     = 1'b1;
                    mem_waddr  = addr_ptr_d[AW-1:1];
                    addr_ptr_d = addr_ptr_d + AW'(2);
                end
                HPI_MAILBOX: begin
                    h2d_data_d = OTG_DATA;
                    h2d_full_d = 1'b1;
                end
                default: ;
            endcase
        end

        if (clr) begin
            addr_ptr_d = '0;
            h2d_data_d = '0;
            d2h_data_d = '0;
            h2d_full_d = 1'b0;
            d2h_full_d = 1'b0;
            rd_port_d  = HPI_DATA;
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            addr_ptr_q <= '0;
            h2d_data_q <= '0;
            d2h_data_q <= '0;
            h2d_full_q <= 1'b0;
            d2h_full_q <= 1'b0;
            rd_port_q  <= HPI_DATA;
        end else begin
            addr_ptr_q <= addr_ptr_d;
            h2d_data_q <= h2d_data_d;
            d2h_data_q <= d2h_data_d;
            h2d_full_q <= h2d_full_d;
            d2h_full_q <= d2h_full_d;
            rd_port_q  <= rd_port_d;
        end
    end

    // Memory contents survive both resets.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= OTG_DATA;
        end
    end

    assign mem_rdata = mem[addr_ptr_q[AW-1:1]];

    always_comb begin
        ptr_word = '0;
        ptr_word[AW-1:0] = addr_ptr_q;
    end

    always_comb begin
        rd_mux = '0;
        case (port_sel)
            HPI_DATA:    rd_mux = mem_rdata;
            HPI_MAILBOX: rd_mux = d2h_data_q;
            HPI_ADDRESS: rd_mux = ptr_word;
            HPI_STATUS:  rd_mux = hpi_status_word(h2d_full_q, d2h_full_q);
            default:     rd_mux = '0;
        endcase
    end

    // Keep the bus released while either reset is asserted.
    assign bus_drive = rd_act & OTG_RST_N & Reset_N;
    assign OTG_DATA  = bus_drive ? rd_mux : 16'hzzzz;

    assign OTG_INT       = d2h_full_q;
    assign dev_mbx_rdata = h2d_data_q;
    assign dev_mbx_valid = h2d_full_q;

endmodule

// File: doc/hpi_target.md
Name: hpi_target

Overview:
- Synthesizable responder for the four-register HPI port: the CY7C67200-side counterpart of the host's HPI I/O interface.
- Decodes OTG_ADDR, OTG_CS_N, OTG_RD_N and OTG_WR_N, and serves an internal word memory through an auto-incrementing address pointer.
- Implements the bidirectional mailbox and the status register, and drives OTG_INT.
- Used as the on-chip HPI peer in loopback builds and as the device model in host-driver testbenches.

Parameters:
- DEPTH, 256: number of 16-bit memory words; power of two, minimum 4.
- AW, $clog2(DEPTH)+1: width of the byte-address bits actually decoded.

Ports:
- Clk  in  1  system clock.
- Reset_N  in  1  asynchronous, active-low reset.
- OTG_DATA  inout  16  HPI data bus; driven only during a valid read, otherwise high-Z.
- OTG_ADDR  in  2  port select: 0=DATA, 1=MAILBOX, 2=ADDRESS, 3=STATUS.
- OTG_RD_N  in  1  read strobe, active low.
- OTG_WR_N  in  1  write strobe, active low.
- OTG_CS_N  in  1  chip select, active low.
- OTG_RST_N  in  1  chip reset from host, active low; acts as a synchronous clear.
- OTG_INT  out  1  interrupt to host; high while the device-to-host mailbox is full.
- dev_mbx_wr  in  1  device-side write of the device-to-host mailbox.
- dev_mbx_wdata  in  16  data for dev_mbx_wr.
- dev_mbx_rdata  out  16  last host-written mailbox value.
- dev_mbx_valid  out  1  host-to-device mailbox full, not yet acknowledged.
- dev_mbx_ack  in  1  device consumed the host-to-device mailbox.

Behaviour:
- Reset_N low, asynchronous: clear addr_ptr, both mailbox data registers, both full flags, and the strobe history registers. Outputs are then OTG_INT=0, dev_mbx_valid=0, dev_mbx_rdata=0, and OTG_DATA is high-Z. Memory contents are not reset.
- OTG_RST_N low, sampled on Clk: same clear as Reset_N, synchronous. While it is low, all strobes are ignored.
- Strobe qualification, combinational from the pins:
  - wr_act = ~CS_N & ~WR_N.
  - rd_act = ~CS_N & ~RD_N & WR_N.
  - If RD and WR are both low, treat the access as a write and do not drive the bus.
- Write commit: exactly once per strobe, in the first cycle wr_act=1 after a cycle with wr_act=0. OTG_DATA and OTG_ADDR are captured in that cycle. A strobe held for N cycles commits once.
  - ADDRESS: addr_ptr <= data[AW-1:0] with bit0 forced to 0.
  - DATA: mem[addr_ptr[AW-1:1]] <= data, then addr_ptr += 2.
  - MAILBOX: h2d_data <= data, h2d_full <= 1.
  - STATUS: ignored.
- Read data: OTG_DATA = rd_act ? rd_mux : 'z. rd_mux is combinational with zero latency, so data is valid in the same cycle the strobe is seen.
  - DATA: mem[addr_ptr[AW-1:1]].
  - MAILBOX: d2h_data.
  - ADDRESS: addr_ptr zero-extended to 16 bits.
  - STATUS: {14'b0, h2d_full, d2h_full}.
- Read side effects occur only at read end: the first cycle rd_act=0 after rd_act=1, using the OTG_ADDR registered during the read.
  - DATA: addr_ptr += 2.
  - MAILBOX: d2h_full <= 0.
  - Other ports: none.
- addr_ptr arithmetic is modulo 2^AW. At address (2*DEPTH-2) an increment wraps to 0.
- Device side:
  - dev_mbx_wr: d2h_data <= wdata, d2h_full <= 1.
  - dev_mbx_ack: h2d_full <= 0.
  - dev_mbx_rdata = h2d_data and dev_mbx_valid = h2d_full, both direct from registers.
- OTG_INT = d2h_full, registered; it rises the cycle after dev_mbx_wr.
- Simultaneous events:
  - dev_mbx_wr in the same cycle as a host MAILBOX read end: the write wins, d2h_full stays 1 and the data updates.
  - dev_mbx_ack in the same cycle as a host MAILBOX write commit: the write wins, h2d_full stays 1.
  - A host read end and a write commit never coincide on one strobe pair; if both occur, apply the read-end increment first, then the write.
- Reset in the middle of a strobe: after release, a strobe still held low does not commit. The strobe history resets to "active", so a fresh high-to-low edge is required.

Decomposition:
- hpi_pkg holds:
  - typedef enum logic [1:0] {HPI_DATA=0, HPI_MAILBOX=1, HPI_ADDRESS=2, HPI_STATUS=3} hpi_port_t;
  - STATUS bit index constants ST_D2H_FULL=0 and ST_H2D_FULL=1.
- One sub-module, hpi_strobe_edge: takes the qualified strobes and produces one-cycle wr_commit and rd_end pulses. It is shared with the host-side bench monitor.

Test Plan:
- Write ADDRESS=0x0010, write DATA 0xAAAA then 0x5555, write ADDRESS=0x0010, read DATA twice -> reads return 0xAAAA then 0x5555; ADDRESS reads back 0x0014.
- WR strobe held low 5 cycles on DATA with ADDRESS=0 -> exactly one memory write; ADDRESS reads back 0x0002.
- dev_mbx_wr with 0x1234 -> OTG_INT=1 next cycle, STATUS=0x0001; host reads MAILBOX=0x1234 -> OTG_INT=0 the cycle after read end, STATUS=0x0000.
- Host writes MAILBOX 0xBEEF -> dev_mbx_valid=1, dev_mbx_rdata=0xBEEF, STATUS=0x0002; dev_mbx_ack in the same cycle as a second host write of 0xCAFE -> valid stays 1, rdata=0xCAFE.
- ADDRESS=(2*DEPTH-2), read DATA -> ADDRESS reads 0x0000; bus is high-Z whenever CS_N=1, and also with RD_N=WR_N=0.
- Pulse OTG_RST_N low, then Reset_N low, in the middle of a WR strobe -> flags clear, OTG_INT=0, no commit until the strobe is deasserted and reasserted.
